// File: rtl/turn_scheduler_if.sv
// Turn scheduler handshake bundle.
// Groups the player/compare/win-check inputs and the turn/strobe outputs of turn_scheduler.
//   new_game, btn, card_valid, card_match, win : game-side inputs to the scheduler
//   T, pick, advance, busy, game_over, winner  : registered scheduler outputs
// master: drives the inputs (board glue or testbench); slave: the scheduler itself.
interface turn_scheduler_if;
  logic       new_game;
  logic       btn;
  logic       card_valid;
  logic       card_match;
  logic       win;
  logic [1:0] T;
  logic       pick;
  logic       advance;
  logic       busy;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output new_game, btn, card_valid, card_match, win,
    input  T, pick, advance, busy, game_over, winner
  );

  modport slave (
    input  new_game, btn, card_valid, card_match, win,
    output T, pick, advance, busy, game_over, winner
  );
endinterface

// File: rtl/turn_scheduler.sv
// Turn scheduler: game-flow controller for the Chicken Cha-Cha-Cha board.
// Owns the turn register T and sequences each move:
//   button pick -> card compare -> advance or pass turn -> win check -> game over.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : turn_scheduler_if.slave
//          in : new_game (start from IDLE/WON), btn (debounced pick button, rising edge used),
//               card_valid / card_match (compare result), win (sampled in CHECK only)
//          out: T (current player), pick / advance (1-cycle strobes), busy, game_over, winner
// All outputs are registered.
module turn_scheduler #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned EVAL_TMO    = 255,
  parameter int unsigned TMO_W       = 8
) (
  input logic             clk,
  input logic             rst,
  turn_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StEval  = 3'd2,
    StAdv   = 3'd3,
    StCheck = 3'd4,
    StPass  = 3'd5,
    StWon   = 3'd6
  } state_e;

  localparam logic [1:0]       LastPlayer = 2'(NUM_PLAYERS - 1);
  // Counter value on the last EVAL cycle before a forced pass.
  localparam logic [TMO_W-1:0] TmoLast    = TMO_W'(EVAL_TMO - 1);

  state_e           state_q;
  logic             btn_q;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       t_q;
  logic [1:0]       winner_q;
  logic             pick_q;
  logic             advance_q;
  logic             busy_q;
  logic             game_over_q;
  logic             btn_rise;

  assign btn_rise = bus.btn & ~btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      btn_q       <= 1'b0;
      tmo_q       <= '0;
      t_q         <= 2'd0;
      winner_q    <= 2'd0;
      pick_q      <= 1'b0;
      advance_q   <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      btn_q     <= bus.btn;
      // Strobes default low so each lasts exactly one cycle.
      pick_q    <= 1'b0;
      advance_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.new_game) begin
            state_q  <= StWait;
            t_q      <= 2'd0;
            winner_q <= 2'd0;
          end
        end
        StWait: begin
          if (btn_rise) begin
            state_q <= StEval;
            pick_q  <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        StEval: begin
          // A valid compare result takes priority over the timeout on the same cycle.
          if (bus.card_valid) begin
            if (bus.card_match) begin
              state_q   <= StAdv;
              advance_q <= 1'b1;
            end else begin
              state_q <= StPass;
              busy_q  <= 1'b0;
            end
          end else if (tmo_q == TmoLast) begin
            state_q <= StPass;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StAdv: begin
          state_q <= StCheck;
        end
        StCheck: begin
          busy_q <= 1'b0;
          if (bus.win) begin
            state_q     <= StWon;
            winner_q    <= t_q;
            game_over_q <= 1'b1;
          end else begin
            state_q <= StWait;
          end
        end
        StPass: begin
          state_q <= StWait;
          t_q     <= (t_q == LastPlayer) ? 2'd0 : t_q + 2'd1;
        end
        StWon: begin
          if (bus.new_game) begin
            state_q     <= StWait;
            t_q         <= 2'd0;
            game_over_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.T         = t_q;
  assign bus.pick      = pick_q;
  assign bus.advance   = advance_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Testbench for turn_scheduler (NUM_PLAYERS=4, EVAL_TMO=5).
// Stimulus pushes a hand-computed move record into a queue; a monitor builds the observed
// record for each busy window and compares it against the popped expectation.
module tb_turn_scheduler;

  typedef struct {
    int t_pick;
    int len;
    int picks;
    int pick_first;
    int advs;
    int adv_pos;
    int t_after;
    int game_over;
    int winner;
  } move_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   total_picks;
  int   stray;
  move_t exp_q[$];

  turn_scheduler_if bus ();

  turn_scheduler #(
    .NUM_PLAYERS (4),
    .EVAL_TMO    (5),
    .TMO_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    move_t obs;
    bit    in_move;
    bit    post;
    in_move = 1'b0;
    post    = 1'b0;
    obs     = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      if (bus.pick && !bus.busy) stray++;
      if (bus.pick) total_picks++;
      if (!rst) begin
        in_move = 1'b0;
        post    = 1'b0;
      end else begin
        if (post) begin
          post          = 1'b0;
          obs.t_after   = int'(bus.T);
          obs.game_over = int'(bus.game_over);
          obs.winner    = int'(bus.winner);
          if (exp_q.size() == 0) begin
            chk("unexpected_move", 1, 0);
          end else begin
            move_t e;
            e = exp_q.pop_front();
            chk("t_pick", obs.t_pick, e.t_pick);
            chk("busy_len", obs.len, e.len);
            chk("pick_count", obs.picks, e.picks);
            chk("pick_first", obs.pick_first, e.pick_first);
            chk("adv_count", obs.advs, e.advs);
            chk("adv_pos", obs.adv_pos, e.adv_pos);
            chk("t_after", obs.t_after, e.t_after);
            chk("game_over", obs.game_over, e.game_over);
            if (e.game_over != 0) chk("winner", obs.winner, e.winner);
          end
        end
        if (bus.busy) begin
          if (!in_move) begin
            in_move        = 1'b1;
            obs            = '{default: 0};
            obs.t_pick     = int'(bus.T);
            obs.pick_first = int'(bus.pick);
          end
          obs.len++;
          if (bus.pick) obs.picks++;
          if (bus.advance) begin
            obs.advs++;
            obs.adv_pos = obs.len;
          end
        end else if (in_move) begin
          in_move = 1'b0;
          post    = 1'b1;
        end
      end
    end
  end

  // One move from WAIT: btn rise, then card_valid on EVAL cycle valid_at (0 = never).
  task automatic move(input int valid_at, input bit match, input bit win_in,
                      input bit pulse_mid, input bit hold,
                      input int e_tpick, input int e_len, input int e_adv_pos,
                      input int e_tafter, input int e_go, input int e_winner);
    move_t m;
    m.t_pick     = e_tpick;
    m.len        = e_len;
    m.picks      = 1;
    m.pick_first = 1;
    m.advs       = (e_adv_pos != 0) ? 1 : 0;
    m.adv_pos    = e_adv_pos;
    m.t_after    = e_tafter;
    m.game_over  = e_go;
    m.winner     = e_winner;
    exp_q.push_back(m);
    @(negedge clk);
    bus.btn = 1'b1;
    @(negedge clk);
    if (!hold) bus.btn = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.card_valid = (c == valid_at) ? 1'b1 : 1'b0;
      bus.card_match = match;
      bus.win        = win_in;
      if (pulse_mid && c == 2) bus.btn = 1'b1;
      if (pulse_mid && c == 3) bus.btn = 1'b0;
      @(negedge clk);
    end
    bus.card_valid = 1'b0;
    bus.card_match = 1'b0;
    bus.win        = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  initial begin
    int picks_before;
    errors         = 0;
    checks         = 0;
    total_picks    = 0;
    stray          = 0;
    rst            = 1'b0;
    bus.new_game   = 1'b0;
    bus.btn        = 1'b0;
    bus.card_valid = 1'b0;
    bus.card_match = 1'b0;
    bus.win        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_T", int'(bus.T), 0);
    chk("rst_pick", int'(bus.pick), 0);
    chk("rst_advance", int'(bus.advance), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_game_over", int'(bus.game_over), 0);
    chk("rst_winner", int'(bus.winner), 0);
    rst = 1'b1;

    // btn in IDLE is ignored.
    @(negedge clk);
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_btn_picks", total_picks, 0);
    chk("idle_busy", int'(bus.busy), 0);

    pulse_new_game();
    // Match on first EVAL cycle, no win: advance on busy cycle 2, T unchanged.
    move(1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 2, 0, 0, 0);
    // Four mismatches: T 0,1,2,3,0.
    move(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1, 0, 0);
    move(1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 2, 0, 0);
    move(1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 3, 0, 0);
    move(1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0);
    // Timeout after 5 EVAL cycles with a btn pulse during EVAL (ignored).
    move(0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 0, 1, 0, 0);
    // card_valid on the 5th EVAL cycle beats the timeout.
    move(5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 7, 6, 1, 0, 0);
    move(1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 2, 0, 0);
    // Player 2 matches and wins.
    move(1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 3, 2, 2, 1, 2);

    picks_before = total_picks;
    @(negedge clk);
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("won_btn_picks", total_picks, picks_before);
    chk("won_game_over", int'(bus.game_over), 1);
    chk("won_winner", int'(bus.winner), 2);
    chk("won_T", int'(bus.T), 2);
    pulse_new_game();
    chk("restart_T", int'(bus.T), 0);
    chk("restart_game_over", int'(bus.game_over), 0);

    // btn held high across and after a move: only one pick.
    picks_before = total_picks;
    move(1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    chk("held_btn_picks", total_picks, picks_before + 1);
    bus.btn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ADV kills the advance strobe at once.
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn        = 1'b0;
    bus.card_valid = 1'b1;
    bus.card_match = 1'b1;
    @(negedge clk);
    bus.card_valid = 1'b0;
    bus.card_match = 1'b0;
    chk("adv_before_rst", int'(bus.advance), 1);
    rst = 1'b0;
    #1;
    chk("adv_after_rst", int'(bus.advance), 0);
    chk("busy_after_rst", int'(bus.busy), 0);
    chk("T_after_rst", int'(bus.T), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_advance", int'(bus.advance), 0);
    pulse_new_game();
    move(1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 2, 0, 0, 0);

    chk("pending_moves", exp_q.size(), 0);
    chk("stray_picks", stray, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
